pipe_alu_param: RTL and testbench

PIPE_ALU_PARAM -- requirements
Module: pipe_alu_param

---
 rtl/pipe_alu_param.sv | 186 ++++++++++++++++++
 tb/tb_pipe_alu_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_param.sv
// ---------------------------------------------------------------------------
// pipe_alu_param
// Four-stage pipelined register-register ALU with a small data memory.
//   S1 operand read -> S2 ALU (with forwarding) -> S3 regbank write / z_out
//   -> S4 data memory write. One instruction per cycle, no stalls.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : instruction present on rs1/rs2/rd/func/addr
//   rs1, rs2  : source register addresses (RAW bits)
//   rd        : destination register address (RAW bits)
//   func      : operation code (0..12 legal, 13..15 illegal)
//   addr      : memory write address, also the LDI immediate (MAW bits)
//   z_out     : result of the instruction in S3
//   z_valid   : z_out holds a valid retiring instruction
//   err       : instruction in S3 carried an illegal func
//   dbg_addr  : debug memory read address
//   dbg_data  : combinational mem[dbg_addr]
// ---------------------------------------------------------------------------
module pipe_alu_param #(
   parameter int DW  = 16,
   parameter int RAW = 4,
   parameter int MAW = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   input  logic [RAW-1:0] rs1,
   input  logic [RAW-1:0] rs2,
   input  logic [RAW-1:0] rd,
   input  logic [3:0]     func,
   input  logic [MAW-1:0] addr,
   output logic [DW-1:0]  z_out,
   output logic           z_valid,
   output logic           err,
   input  logic [MAW-1:0] dbg_addr,
   output logic [DW-1:0]  dbg_data
);

   localparam int NREG = 1 << RAW;
   localparam int NMEM = 1 << MAW;

   logic [DW-1:0]  r_rf  [NREG];
   logic [DW-1:0]  r_mem [NMEM];

   logic           r_vld_p1;
   logic [DW-1:0]  r_a_p1, r_b_p1;
   logic [RAW-1:0] r_rs1_p1, r_rs2_p1, r_rd_p1;
   logic [3:0]     r_func_p1;
   logic [MAW-1:0] r_addr_p1;

   logic           r_vld_p2, r_ill_p2;
   logic [DW-1:0]  r_res_p2;
   logic [RAW-1:0] r_rd_p2;
   logic [MAW-1:0] r_addr_p2;

   logic           r_vld_p3, r_ill_p3;
   logic [DW-1:0]  r_res_p3;
   logic [RAW-1:0] r_rd_p3;
   logic [MAW-1:0] r_addr_p3;

   logic           w_fwd2_ok, w_fwd3_ok;
   logic [DW-1:0]  w_a, w_b;
   logic [DW:0]    w_alu;

   // Returns {illegal, result}; illegal codes yield a zero result.
   function automatic logic [DW:0] alu_op(input logic [3:0] f,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [MAW-1:0] imm);
      logic [DW-1:0] res;
      logic          ill;
      res = '0;
      ill = 1'b0;
      case (f)
         4'd0:    res = a + b;
         4'd1:    res = a - b;
         4'd2:    res = a * b;
         4'd3:    res = a;
         4'd4:    res = b;
         4'd5:    res = a & b;
         4'd6:    res = a | b;
         4'd7:    res = a ^ b;
         4'd8:    res = ~a;
         4'd9:    res = ~b;
         4'd10:   res = a >> 1;
         4'd11:   res = a << 1;
         4'd12:   res = DW'(imm);
         default: ill = 1'b1;
      endcase
      return {ill, res};
   endfunction

   // ---- S1: operand read into L12 ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1  <= 1'b0;
         r_a_p1    <= '0;
         r_b_p1    <= '0;
         r_rs1_p1  <= '0;
         r_rs2_p1  <= '0;
         r_rd_p1   <= '0;
         r_func_p1 <= '0;
         r_addr_p1 <= '0;
      end else begin
         r_vld_p1  <= in_valid;
         r_a_p1    <= r_rf[rs1];
         r_b_p1    <= r_rf[rs2];
         r_rs1_p1  <= rs1;
         r_rs2_p1  <= rs2;
         r_rd_p1   <= rd;
         r_func_p1 <= func;
         r_addr_p1 <= addr;
      end
   end

   // ---- S2: forwarding and ALU, result into L23 ----
   // L23 holds the previous instruction, L34 the one before it. The L34
   // instruction wrote the regbank on the same edge S1 read it, so S1 saw
   // the old value and forwarding from L34 is still required.
   assign w_fwd2_ok = r_vld_p2 && !r_ill_p2 && (r_rd_p2 != '0);
   assign w_fwd3_ok = r_vld_p3 && !r_ill_p3 && (r_rd_p3 != '0);

   assign w_a = (w_fwd2_ok && (r_rd_p2 == r_rs1_p1)) ? r_res_p2 :
                (w_fwd3_ok && (r_rd_p3 == r_rs1_p1)) ? r_res_p3 : r_a_p1;
   assign w_b = (w_fwd2_ok && (r_rd_p2 == r_rs2_p1)) ? r_res_p2 :
                (w_fwd3_ok && (r_rd_p3 == r_rs2_p1)) ? r_res_p3 : r_b_p1;

   assign w_alu = alu_op(r_func_p1, w_a, w_b, r_addr_p1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p2  <= 1'b0;
         r_ill_p2  <= 1'b0;
         r_res_p2  <= '0;
         r_rd_p2   <= '0;
         r_addr_p2 <= '0;
      end else begin
         r_vld_p2  <= r_vld_p1;
         r_ill_p2  <= w_alu[DW];
         r_res_p2  <= w_alu[DW-1:0];
         r_rd_p2   <= r_rd_p1;
         r_addr_p2 <= r_addr_p1;
      end
   end

   // ---- S3: regbank write and L34 load (z_out) ----
   // Register 0 is never written, so it reads 0 forever after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (r_vld_p2 && !r_ill_p2 && (r_rd_p2 != '0)) begin
         r_rf[r_rd_p2] <= r_res_p2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p3  <= 1'b0;
         r_ill_p3  <= 1'b0;
         r_res_p3  <= '0;
         r_rd_p3   <= '0;
         r_addr_p3 <= '0;
      end else begin
         r_vld_p3  <= r_vld_p2;
         r_ill_p3  <= r_ill_p2;
         r_res_p3  <= r_res_p2;
         r_rd_p3   <= r_rd_p2;
         r_addr_p3 <= r_addr_p2;
      end
   end

   assign z_out   = r_res_p3;
   assign z_valid = r_vld_p3;
   assign err     = r_vld_p3 & r_ill_p3;

   // ---- S4: data memory write ----
   // Memory is not reset; reset clears r_vld_p3 so no in-flight write lands.
   always_ff @(posedge clk) begin
      if (r_vld_p3 && !r_ill_p3) r_mem[r_addr_p3] <= r_res_p3;
   end

   assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_pipe_alu_param.sv
module tb_pipe_alu_param;

   typedef struct {
      logic        v;
      logic [3:0]  f;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [3:0]  d;
      logic [7:0]  ad;
      logic [15:0] ez;
      logic        ee;
   } vec_t;

   typedef struct {
      logic [15:0] z;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
   logic [7:0]  addr = '0, dbg_addr = '0;
   logic [15:0] z_out, dbg_data;
   logic        z_valid, err;

   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;
   exp_t sb[$];
   vec_t tbl[$];

   pipe_alu_param #(.DW(16), .RAW(4), .MAW(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
      .z_out(z_out), .z_valid(z_valid), .err(err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] f, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] d,
                               input logic [7:0] ad, input logic [15:0] ez,
                               input logic ee);
      vec_t t;
      t.v = v; t.f = f; t.a = a; t.b = b; t.d = d; t.ad = ad; t.ez = ez; t.ee = ee;
      return t;
   endfunction

   task automatic issue(input vec_t t);
      exp_t e;
      @(posedge clk); #1;
      in_valid = t.v; func = t.f; rs1 = t.a; rs2 = t.b; rd = t.d; addr = t.ad;
      if (t.v) begin
         e.z = t.ez; e.e = t.ee;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic mem_chk(input logic [7:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      chk($sformatf("mem[%h]", a), dbg_data, exp);
   endtask

   // Scoreboard monitor: results retire in issue order.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (z_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_z_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("z_out", z_out, e.z);
               chk("err", err, e.e);
            end
         end else begin
            chk("err_idle", err, 0);
         end
      end
   end

   initial begin
      // Architectural results of each instruction, in issue order.
      tbl.push_back(mk(1, 12, 0, 0, 1, 8'h05, 16'h0005, 0)); // LDI r1,5
      tbl.push_back(mk(1, 12, 0, 0, 2, 8'h03, 16'h0003, 0)); // LDI r2,3
      tbl.push_back(mk(1,  0, 1, 2, 3, 8'h10, 16'h0008, 0)); // ADD r3
      tbl.push_back(mk(1,  1, 2, 1, 4, 8'h11, 16'hFFFE, 0)); // SUB r4
      tbl.push_back(mk(1, 12, 0, 0, 5, 8'hFF, 16'h00FF, 0)); // LDI r5
      tbl.push_back(mk(1, 12, 0, 0, 6, 8'hFF, 16'h00FF, 0)); // LDI r6
      tbl.push_back(mk(1,  2, 5, 6, 7, 8'h12, 16'hFE01, 0)); // MUL r7
      tbl.push_back(mk(1, 11, 7, 0, 9, 8'h14, 16'hFC02, 0)); // SHL r9
      tbl.push_back(mk(1, 10, 7, 0,10, 8'h15, 16'h7F00, 0)); // SHR r10
      tbl.push_back(mk(1, 12, 0, 0, 0, 8'h33, 16'h0033, 0)); // LDI r0
      tbl.push_back(mk(1,  0, 0, 0, 8, 8'h13, 16'h0000, 0)); // ADD r8=r0+r0
      tbl.push_back(mk(1,  5, 5, 4,11, 8'h16, 16'h00FE, 0)); // AND
      tbl.push_back(mk(1,  6, 2, 1,12, 8'h17, 16'h0007, 0)); // OR
      tbl.push_back(mk(1,  7, 3, 1,13, 8'h18, 16'h000D, 0)); // XOR
      tbl.push_back(mk(1,  8, 1, 0,14, 8'h19, 16'hFFFA, 0)); // NOT A
      tbl.push_back(mk(1,  9, 0, 2,15, 8'h1A, 16'hFFFC, 0)); // NOT B
      tbl.push_back(mk(1,  3, 9, 0, 0, 8'h1B, 16'hFC02, 0)); // PASS A
      tbl.push_back(mk(1,  4, 0,10, 0, 8'h1C, 16'h7F00, 0)); // PASS B
      tbl.push_back(mk(1,  0, 7, 9,11, 8'h1D, 16'hFA03, 0)); // ADD wrap
      tbl.push_back(mk(1,  3, 1, 0, 0, 8'h20, 16'h0005, 0)); // mem[20]=5
      tbl.push_back(mk(0, 12, 0, 0, 1, 8'h20, 16'h0000, 0)); // bubble, must not write
      tbl.push_back(mk(1, 14, 1, 1, 1, 8'h20, 16'h0000, 1)); // illegal
      tbl.push_back(mk(1,  3, 1, 0, 0, 8'h21, 16'h0005, 0)); // r1 still 5
      tbl.push_back(mk(1,  3, 3, 0, 0, 8'h30, 16'h0008, 0));
      tbl.push_back(mk(1,  3, 3, 0, 0, 8'h31, 16'h0008, 0));
      tbl.push_back(mk(1,  3, 3, 0, 0, 8'h32, 16'h0008, 0));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_z_out", z_out, 0);
      chk("rst_z_valid", z_valid, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);
      idle();
      drain();

      mem_chk(8'h10, 16'h0008);
      mem_chk(8'h11, 16'hFFFE);
      mem_chk(8'h12, 16'hFE01);
      mem_chk(8'h13, 16'h0000);
      mem_chk(8'h14, 16'hFC02);
      mem_chk(8'h20, 16'h0005);
      mem_chk(8'h21, 16'h0005);

      // Reset with instructions in flight
      mon_en = 1'b0;
      @(posedge clk); #1;
      in_valid = 1; func = 12; rs1 = 0; rs2 = 0; rd = 14; addr = 8'h40;
      @(posedge clk); #1;
      func = 0; rs1 = 2; rs2 = 2; rd = 1; addr = 8'h30;
      @(posedge clk); #1;
      rd = 2; addr = 8'h31;
      @(posedge clk); #1;
      rd = 3; addr = 8'h32;
      chk("pre_rst_z_valid", z_valid, 1);
      chk("pre_rst_z_out", z_out, 16'h0040);
      rst_n = 1'b0;
      #1;
      chk("async_rst_z_valid", z_valid, 0);
      chk("async_rst_z_out", z_out, 0);
      chk("async_rst_err", err, 0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_chk(8'h30, 16'h0008);
      mem_chk(8'h31, 16'h0008);
      mem_chk(8'h32, 16'h0008);

      mon_en = 1'b1;
      for (int r = 1; r < 16; r++) issue(mk(1, 3, 4'(r), 0, 0, 8'(8'h50 + r), 16'h0000, 0));
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
